sysid_regs: RTL and testbench
=============================

# sysid_regs

Parametrised system-identification register bank: successor to the fixed two-word sysid slave. Adds a build timestamp, a scratch register for bus sanity checks, a prescaled 64-bit uptime counter with atomic snapshot, and registered read data with fixed latency. Sits on the Qsys Avalon-MM interconnect as a control slave. Host software uses it to confirm the loaded image and to measure elapsed time.

## Interface
- SYSID, 32'hCAFE0001: value returned by the ID register.
- TIMESTAMP, 32'h00000000: build time, Unix seconds, returned by the TIMESTAMP register.
- DEFAULT_PRESCALE, 0: reset value of the PRESCALE register.
- CNT_W, 64: uptime counter width. Legal range 33..64; the upper word is zero-extended.

- clock  in  1  single clock, rising edge.
- reset_n  in  1  reset, synchronous and active-low.
- address  in  3  word address.
- read  in  1  read strobe, one cycle per access.
- write  in  1  write strobe, one cycle per access.
- writedata  in  32  write data.
- byteenable  in  4  byte lanes for writes.
- readdata  out  32  registered read data.
- readdatavalid  out  1  high for one cycle, exactly 1 cycle after read.

## Operation
- Register map (word addresses):
  - 0 ID: RO, returns SYSID.
  - 1 TIMESTAMP: RO.
  - 2 SCRATCH: RW, 32 bits, byteenable honoured, reset 0.
  - 3 CTRL:
    - bit0 EN: RW, reset 1.
    - bit1 CLR: write 1 clears the counter and prescaler; self-clearing, reads 0.
    - bit8 OVF: sticky; set on counter wrap; write 1 clears.
    - Other bits read 0.
    - Writes apply only when byteenable[0] is set for bits 0..1, and byteenable[1] for bit 8.
  - 4 UPTIME_LO: RO, returns counter[31:0]. The same read latches counter[CNT_W-1:32] into the shadow register.
  - 5 UPTIME_HI: RO, returns the shadow register, reset 0.
  - 6 PRESCALE: RW, 32 bits, byteenable honoured, reset DEFAULT_PRESCALE.
  - 7: reserved, reads 0, writes ignored.
- Writes to RO addresses are ignored.
- Prescaler:
  - Internal 32-bit count. While EN=1 it increments each clock.
  - When count == PRESCALE it wraps to 0 and issues a tick, so there is one tick per PRESCALE+1 clocks.
  - While EN=0 the count holds.
- Counter: increments by 1 on each tick.
  - All-ones wraps to 0 and sets OVF in the same cycle.
- A write to PRESCALE also zeroes the prescaler count.
- Precedence within one cycle:
  - CLR beats tick.
  - OVF set beats OVF write-1-clear.
  - Writing EN=0 suppresses a tick in that same cycle.
- Simultaneous read and write to the same address: the read returns the pre-write value.
- Snapshot: the LO read and the HI latch sample the counter value before that edge's increment. A LO/HI pair is therefore always consistent.

## Timing
- Read latency is fixed at 1 cycle; there is no waitrequest. Back-to-back reads on every cycle are legal.
- readdata holds its last value when readdatavalid=0.
- A write takes effect at the edge on which write is sampled. A read on the next cycle sees the new value.
- Reset, synchronous while reset_n=0 at the edge:
  - readdata=0, readdatavalid=0.
  - SCRATCH=0, EN=1, OVF=0, counter=0, prescaler=0, shadow=0, PRESCALE=DEFAULT_PRESCALE.
- A read in flight during reset is dropped: no readdatavalid follows.
- With PRESCALE=0 the counter increments every clock.

## Test plan
- Reset, then read addresses 0, 1 and 7 -> readdatavalid exactly 1 cycle later, with readdata=SYSID, TIMESTAMP and 0 respectively.
- SCRATCH:
  - write 32'h12345678 with byteenable=4'b1111, then write 32'hFFFFFFFF with byteenable=4'b0101 -> read returns 32'h12FF56FF;
  - write 32'hDEAD to address 0 -> ID is unchanged.
- Prescale:
  - write PRESCALE=3, wait 40 clocks, read UPTIME_LO -> 10 ± 1;
  - write CTRL EN=0, wait 100 clocks -> the value is unchanged.
- Snapshot and wrap:
  - force the counter to 64'h00000000_FFFFFFFE via CLR plus a bench hierarchical deposit; PRESCALE=0.
  - Read LO, then HI -> (FFFFFFFE+k, 0), with the pair consistent.
  - After the wrap of the 64-bit all-ones value -> counter=0 and OVF=1.
  - Write CTRL=32'h100 -> OVF=0.
- CLR on the same cycle as a tick -> the counter reads 0, not 1, on the next cycle.
- Assert reset_n low for 1 cycle during back-to-back reads -> no readdatavalid for the read issued that cycle, and all registers return to their reset values.

Source files
------------

// File: rtl/sysid_regs.sv
// System-identification register bank: ID, build timestamp, scratch, and a
// prescaled uptime counter whose upper word is snapshotted by the LO read.
module sysid_regs #(
   parameter logic [31:0] SYSID            = 32'hCAFE0001,
   parameter logic [31:0] TIMESTAMP        = 32'h00000000,
   parameter logic [31:0] DEFAULT_PRESCALE = 32'd0,
   parameter int          CNT_W            = 64
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [2:0]  address,
   input  logic        read,
   input  logic        write,
   input  logic [31:0] writedata,
   input  logic [3:0]  byteenable,
   output logic [31:0] readdata,
   output logic        readdatavalid
);
   localparam int HI_W = CNT_W - 32;

   localparam logic [2:0] ADDR_ID       = 3'd0;
   localparam logic [2:0] ADDR_TS       = 3'd1;
   localparam logic [2:0] ADDR_SCRATCH  = 3'd2;
   localparam logic [2:0] ADDR_CTRL     = 3'd3;
   localparam logic [2:0] ADDR_LO       = 3'd4;
   localparam logic [2:0] ADDR_HI       = 3'd5;
   localparam logic [2:0] ADDR_PRESCALE = 3'd6;

   logic [31:0]      scratch_q, scratch_d;
   logic [31:0]      prescale_q, prescale_d;
   logic [31:0]      pre_cnt_q, pre_cnt_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [HI_W-1:0]  shadow_q, shadow_d;
   logic             en_q, en_d;
   logic             ovf_q, ovf_d;
   logic [31:0]      readdata_q, readdata_d;
   logic             rdv_q, rdv_d;

   logic        wr_ctrl, wr_prescale, clr, tick, wrap;
   logic [31:0] hi_word, ctrl_word, rd_mux;

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  be);
      logic [31:0] res;
      res = old_val;
      for (int b = 0; b < 4; b++) begin
         if (be[b]) res[8*b +: 8] = wdata[8*b +: 8];
      end
      return res;
   endfunction

   // Read mux always sees pre-write state, so a same-cycle write is not visible.
   always_comb begin
      hi_word              = '0;
      hi_word[HI_W-1:0]    = shadow_q;
      ctrl_word            = '0;
      ctrl_word[0]         = en_q;
      ctrl_word[8]         = ovf_q;
      case (address)
         ADDR_ID:       rd_mux = SYSID;
         ADDR_TS:       rd_mux = TIMESTAMP;
         ADDR_SCRATCH:  rd_mux = scratch_q;
         ADDR_CTRL:     rd_mux = ctrl_word;
         ADDR_LO:       rd_mux = cnt_q[31:0];
         ADDR_HI:       rd_mux = hi_word;
         ADDR_PRESCALE: rd_mux = prescale_q;
         default:       rd_mux = '0;
      endcase
   end

   always_comb begin
      wr_ctrl     = write && (address == ADDR_CTRL);
      wr_prescale = write && (address == ADDR_PRESCALE);

      en_d = en_q;
      if (wr_ctrl && byteenable[0]) en_d = writedata[0];
      clr = wr_ctrl && byteenable[0] && writedata[1];

      // The incoming EN value gates this cycle, so writing EN=0 suppresses the tick.
      tick = en_d && (pre_cnt_q == prescale_q);

      pre_cnt_d = pre_cnt_q;
      if (clr || wr_prescale)  pre_cnt_d = '0;
      else if (en_d)           pre_cnt_d = tick ? 32'd0 : pre_cnt_q + 32'd1;

      cnt_d = cnt_q;
      wrap  = 1'b0;
      if (clr) begin
         cnt_d = '0;
      end else if (tick) begin
         cnt_d = cnt_q + CNT_W'(1);
         wrap  = (cnt_q == '1);
      end

      ovf_d = ovf_q;
      if (wr_ctrl && byteenable[1] && writedata[8]) ovf_d = 1'b0;
      if (wrap)                                      ovf_d = 1'b1;

      scratch_d  = (write && address == ADDR_SCRATCH)
                   ? merge_bytes(scratch_q, writedata, byteenable) : scratch_q;
      prescale_d = wr_prescale ? merge_bytes(prescale_q, writedata, byteenable) : prescale_q;

      shadow_d = shadow_q;
      if (read && address == ADDR_LO) shadow_d = cnt_q[CNT_W-1:32];

      rdv_d      = read;
      readdata_d = read ? rd_mux : readdata_q;
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         scratch_q  <= '0;
         prescale_q <= DEFAULT_PRESCALE;
         pre_cnt_q  <= '0;
         cnt_q      <= '0;
         shadow_q   <= '0;
         en_q       <= 1'b1;
         ovf_q      <= 1'b0;
         readdata_q <= '0;
         rdv_q      <= 1'b0;
      end else begin
         scratch_q  <= scratch_d;
         prescale_q <= prescale_d;
         pre_cnt_q  <= pre_cnt_d;
         cnt_q      <= cnt_d;
         shadow_q   <= shadow_d;
         en_q       <= en_d;
         ovf_q      <= ovf_d;
         readdata_q <= readdata_d;
         rdv_q      <= rdv_d;
      end
   end

   assign readdata      = readdata_q;
   assign readdatavalid = rdv_q;
endmodule

// File: tb/tb_sysid_regs.sv
// Bench for sysid_regs: directed register-map steps plus a random phase, all
// checked every cycle against a register-level model of the map.
module tb_sysid_regs;
   localparam logic [31:0] SYSID_P = 32'hCAFE0001;
   localparam logic [31:0] TS_P    = 32'h6650A1B2;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        read = 1'b0;
   logic        write = 1'b0;
   logic [2:0]  address = '0;
   logic [31:0] writedata = '0;
   logic [3:0]  byteenable = '0;
   logic [31:0] readdata;
   logic        readdatavalid;

   int errors = 0;
   int checks = 0;

   logic [31:0] m_scratch, m_prescale, m_pre, m_shadow, m_data;
   logic [63:0] m_cnt;
   logic        m_en, m_ovf, m_rdv;
   logic [31:0] held;

   always #5 clock = ~clock;

   sysid_regs #(
      .SYSID(SYSID_P), .TIMESTAMP(TS_P), .DEFAULT_PRESCALE(32'd0), .CNT_W(64)
   ) dut (
      .clock(clock), .reset_n(reset_n), .address(address), .read(read),
      .write(write), .writedata(writedata), .byteenable(byteenable),
      .readdata(readdata), .readdatavalid(readdatavalid)
   );

   function automatic logic [31:0] bytes_upd(input logic [31:0] o, input logic [31:0] w,
                                             input logic [3:0] be);
      logic [31:0] r;
      r = o;
      for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = w[8*b +: 8];
      return r;
   endfunction

   function automatic logic [31:0] m_read(input logic [2:0] a);
      case (a)
         3'd0: return SYSID_P;
         3'd1: return TS_P;
         3'd2: return m_scratch;
         3'd3: return {23'd0, m_ovf, 7'd0, m_en};
         3'd4: return m_cnt[31:0];
         3'd5: return m_shadow;
         3'd6: return m_prescale;
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_edge(input logic rst, input logic rd, input logic wr,
                             input logic [2:0] a, input logic [31:0] wd, input logic [3:0] be);
      logic run, clr, tick, ovf_clr;
      if (!rst) begin
         m_scratch = 0; m_prescale = 0; m_pre = 0; m_shadow = 0; m_cnt = 0;
         m_en = 1; m_ovf = 0; m_rdv = 0; m_data = 0;
         return;
      end
      m_rdv = rd;
      if (rd) begin
         m_data = m_read(a);
         if (a == 3'd4) m_shadow = m_cnt[63:32];
      end
      run = m_en; clr = 0; ovf_clr = 0;
      if (wr && a == 3'd2) m_scratch = bytes_upd(m_scratch, wd, be);
      if (wr && a == 3'd3) begin
         if (be[0]) begin run = wd[0]; clr = wd[1]; end
         ovf_clr = be[1] & wd[8];
      end
      tick = run && (m_pre == m_prescale);
      m_en = run;
      if (clr || (wr && a == 3'd6)) m_pre = 0;
      else if (run)                 m_pre = tick ? 32'd0 : m_pre + 1;
      if (wr && a == 3'd6) m_prescale = bytes_upd(m_prescale, wd, be);
      if (ovf_clr) m_ovf = 0;
      if (clr) m_cnt = 0;
      else if (tick) begin
         if (m_cnt == 64'hFFFF_FFFF_FFFF_FFFF) begin m_cnt = 0; m_ovf = 1; end
         else m_cnt = m_cnt + 1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step(input string tag, input logic rst, input logic rd, input logic wr,
                       input logic [2:0] a, input logic [31:0] wd, input logic [3:0] be);
      reset_n = rst; read = rd; write = wr; address = a; writedata = wd; byteenable = be;
      model_edge(rst, rd, wr, a, wd, be);
      @(posedge clock); #1;
      check({tag, "/rdv"}, {31'd0, readdatavalid}, {31'd0, m_rdv});
      check({tag, "/data"}, readdata, m_data);
      $display("%0t %s rst_n=%0b rd=%0b wr=%0b a=%0d wd=%h be=%h -> rdv=%0b rdata=%h",
               $time, tag, rst, rd, wr, a, wd, be, readdatavalid, readdata);
   endtask

   task automatic rd(input logic [2:0] a, input string tag);
      step(tag, 1'b1, 1'b1, 1'b0, a, 32'd0, 4'h0);
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] wd, input logic [3:0] be,
                     input string tag);
      step(tag, 1'b1, 1'b0, 1'b1, a, wd, be);
   endtask

   task automatic idle(input int n, input string tag);
      for (int i = 0; i < n; i++) step(tag, 1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 4'h0);
   endtask

   initial begin
      step("reset", 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 4'h0);
      step("reset", 1'b0, 1'b1, 1'b0, 3'd0, 32'd0, 4'h0);
      rd(3'd0, "id");   check("id_const", readdata, SYSID_P);
      rd(3'd1, "ts");   check("ts_const", readdata, TS_P);
      rd(3'd7, "rsvd"); check("rsvd_zero", readdata, 32'd0);
      rd(3'd3, "ctrl_reset"); check("ctrl_reset_const", readdata, 32'h1);

      wr(3'd2, 32'h12345678, 4'hF, "scr_w1");
      wr(3'd2, 32'hFFFFFFFF, 4'b0101, "scr_w2");
      rd(3'd2, "scr_rd"); check("scr_const", readdata, 32'h12FF56FF);
      wr(3'd0, 32'h0000DEAD, 4'hF, "id_w");
      rd(3'd0, "id_after_w"); check("id_unchanged", readdata, SYSID_P);

      wr(3'd6, 32'd3, 4'hF, "pre3");
      wr(3'd3, 32'h3, 4'h1, "en_clr");
      idle(40, "run40");
      rd(3'd4, "lo_after40");
      checks++;
      assert (readdata >= 32'd9 && readdata <= 32'd11) else begin
         errors++;
         $error("FAIL lo_range observed=%0d expected=9..11", readdata);
      end
      wr(3'd3, 32'h0, 4'h1, "en0");
      rd(3'd4, "lo_hold0"); held = m_data;
      idle(100, "hold100");
      rd(3'd4, "lo_hold1"); check("lo_hold_const", readdata, held);

      // Snapshot across the 32-bit boundary
      wr(3'd3, 32'h2, 4'h1, "clr_dep");
      force dut.cnt_q = 64'h00000000_FFFFFFFE;
      m_cnt = 64'h00000000_FFFFFFFE;
      idle(2, "dep");
      release dut.cnt_q;
      idle(1, "dep");
      wr(3'd6, 32'd0, 4'hF, "pre0");
      wr(3'd3, 32'h1, 4'h1, "en1");
      rd(3'd4, "snap_lo"); check("snap_lo_const", readdata, 32'hFFFFFFFF);
      rd(3'd5, "snap_hi"); check("snap_hi_const", readdata, 32'h0);
      rd(3'd4, "snap_lo2");
      rd(3'd5, "snap_hi2"); check("snap_hi2_const", readdata, 32'h1);

      // 64-bit wrap sets OVF
      wr(3'd3, 32'h0, 4'h1, "en0_w");
      wr(3'd3, 32'h2, 4'h1, "clr_w");
      force dut.cnt_q = 64'hFFFFFFFF_FFFFFFFD;
      m_cnt = 64'hFFFFFFFF_FFFFFFFD;
      idle(2, "dep64");
      release dut.cnt_q;
      idle(1, "dep64");
      wr(3'd3, 32'h1, 4'h1, "en1_w");
      idle(2, "wrap");
      rd(3'd3, "ovf_set"); check("ovf_set_const", readdata, 32'h101);
      rd(3'd4, "lo_wrap");
      rd(3'd5, "hi_wrap"); check("hi_wrap_const", readdata, 32'h0);
      wr(3'd3, 32'h100, 4'hF, "ovf_clr");
      rd(3'd3, "ovf_cleared"); check("ovf_clr_const", readdata, 32'h0);

      // OVF set wins over a same-cycle write-1-clear
      wr(3'd3, 32'h2, 4'h1, "clr_w2");
      force dut.cnt_q = 64'hFFFFFFFF_FFFFFFFF;
      m_cnt = 64'hFFFFFFFF_FFFFFFFF;
      idle(2, "depmax");
      release dut.cnt_q;
      idle(1, "depmax");
      wr(3'd3, 32'h101, 4'b0011, "en_and_clr_ovf");
      rd(3'd3, "ovf_wins"); check("ovf_wins_const", readdata, 32'h101);
      wr(3'd3, 32'h101, 4'b0010, "ovf_clr2");

      // CLR coincident with a tick (PRESCALE=0, EN=1)
      idle(3, "ticking");
      wr(3'd3, 32'h3, 4'h1, "clr_tick");
      rd(3'd4, "lo_after_clr"); check("clr_tick_const", readdata, 32'h0);

      // Reset pulse during back-to-back reads
      wr(3'd2, 32'hA5A5A5A5, 4'hF, "scr_pre_rst");
      wr(3'd6, 32'd7, 4'hF, "pre_pre_rst");
      rd(3'd2, "bb0");
      rd(3'd6, "bb1");
      step("bb_rst", 1'b0, 1'b1, 1'b0, 3'd2, 32'd0, 4'h0);
      check("bb_rst_rdv_const", {31'd0, readdatavalid}, 32'd0);
      for (int a = 0; a < 8; a++) rd(3'(a), "post_rst");
      rd(3'd2, "scr_post"); check("scr_post_const", readdata, 32'h0);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         logic [2:0]  ra;
         logic [31:0] rwd;
         int op;
         ra  = 3'($urandom_range(0, 7));
         op  = $urandom_range(0, 3);
         rwd = (ra == 3'd6) ? 32'($urandom_range(0, 5)) : $urandom;
         if ($urandom_range(0, 63) == 0)
            step("rnd_rst", 1'b0, op[0], op[1], ra, rwd, 4'($urandom_range(0, 15)));
         else
            step("rnd", 1'b1, op[0], op[1], ra, rwd, 4'($urandom_range(0, 15)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
